// File: rtl/inst_axi_rbridge.sv
// Instruction-fetch bridge: turns IF-stage SRAM-style fetch requests into
// single-beat AXI read transactions, with at most one transfer in flight.
module inst_axi_rbridge #(
  parameter logic [3:0] ARID = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] araddr_q;
  logic [31:0] rdata_q;
  logic        rbeat_match;

  // Write side and response code are deliberately not consumed.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, rresp};

  assign rbeat_match = rvalid && (rid == ARID) && rlast;

  // Handshake outputs are gated with resetn so they stay quiet during reset
  // even before the state register has been cleared.
  assign inst_sram_addr_ok = resetn && inst_sram_req && (state_q == S_IDLE);
  assign arvalid           = resetn && (state_q == S_AR);
  assign rready            = resetn && (state_q == S_R);
  assign inst_sram_data_ok = rready && rbeat_match;
  assign inst_sram_rdata   = inst_sram_data_ok ? rdata : rdata_q;

  assign arid    = ARID;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      araddr_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inst_sram_req) begin
            araddr_q <= inst_sram_addr;
            state_q  <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            state_q <= S_R;
          end
        end
        S_R: begin
          // Beats for other IDs are accepted and discarded.
          if (rbeat_match) begin
            rdata_q <= rdata;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_axi_rbridge.sv
// Self-checking bench for inst_axi_rbridge: directed AXI slave behaviour per
// scenario, expected fetch data queued on addr_ok and compared on data_ok.
module tb_inst_axi_rbridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  inst_axi_rbridge #(.ARID(4'h0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1234_5670;
    arready = 1'b1; rvalid = 1'b1; rid = 4'h0; rlast = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hs_before_edge: got %b want 0000",
               {arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok});
    end
    tick(); tick();
    checks++;
    if ({arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hs_during: got %b want 0000",
               {arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok});
    end
    checks++;
    if (araddr !== 32'h0 || inst_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: araddr=%h rdata=%h want 0/0", araddr, inst_sram_rdata);
    end
    inst_sram_req = 1'b0; arready = 1'b0; rvalid = 1'b0; resetn = 1'b1;
    tick();
    checks++;
    if ({arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok} !== 4'b0000 ||
        araddr !== 32'h0 || inst_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_after: hs=%b araddr=%h rdata=%h want 0000/0/0",
               {arvalid, rready, inst_sram_data_ok, inst_sram_addr_ok}, araddr, inst_sram_rdata);
    end
  endtask

  task automatic test_basic_fetch();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    inst_sram_wen = 4'hF; inst_sram_wdata = $urandom;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL basic_addr_ok: got %b want 1", inst_sram_addr_ok);
    end
    exp_q.push_back(32'h3C1D_0001);
    tick();
    inst_sram_req = 1'b0; inst_sram_addr = 32'h0; inst_sram_wdata = $urandom;
    arready = 1'b1;
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || rready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ar: arvalid=%b araddr=%h rready=%b want 1/bfc00000/0", arvalid, araddr, rready);
    end
    checks++;
    if ({arid, arlen, arsize, arburst, arlock, arcache, arprot} !==
        {4'h0, 8'h00, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000}) begin
      errors++;
      $display("FAIL basic_payload: id=%h len=%h size=%b burst=%b lock=%b cache=%h prot=%b",
               arid, arlen, arsize, arburst, arlock, arcache, arprot);
    end
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'h0; rlast = 1'b1; rdata = 32'h3C1D_0001; rresp = 2'b10;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b1 || rready !== 1'b1 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_data_ok: data_ok=%b rready=%b arvalid=%b want 1/1/0",
               inst_sram_data_ok, rready, arvalid);
    end
    if (inst_sram_data_ok === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL basic_scoreboard: data_ok with empty queue");
      end else begin
        exp_word = exp_q.pop_front();
        if (inst_sram_rdata !== exp_word) begin
          errors++; $display("FAIL basic_rdata: got %h want %h", inst_sram_rdata, exp_word);
        end
      end
    end
    tick();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; inst_sram_wen = 4'h0;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b0 || inst_sram_rdata !== 32'h3C1D_0001 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: data_ok=%b rdata=%h arvalid=%b want 0/3c1d0001/0",
               inst_sram_data_ok, inst_sram_rdata, arvalid);
    end
  endtask

  task automatic test_ar_stall();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1000_0040;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL stall_addr_ok: got %b want 1", inst_sram_addr_ok);
    end
    exp_q.push_back(32'hA5A5_0F0F);
    tick();
    inst_sram_addr = 32'h1000_0044;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h1000_0040 || inst_sram_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: arvalid=%b araddr=%h addr_ok=%b want 1/10000040/0",
                 i, arvalid, araddr, inst_sram_addr_ok);
      end
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'h0; rlast = 1'b1; rdata = 32'hA5A5_0F0F;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL stall_data_ok: data_ok=%b addr_ok=%b want 1/0", inst_sram_data_ok, inst_sram_addr_ok);
    end
    if (inst_sram_data_ok === 1'b1) begin
      checks++;
      exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      if (inst_sram_rdata !== exp_word) begin
        errors++; $display("FAIL stall_rdata: got %h want %h", inst_sram_rdata, exp_word);
      end
    end
    tick();
    rvalid = 1'b0;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL stall_back_idle: addr_ok=%b arvalid=%b want 1/0", inst_sram_addr_ok, arvalid);
    end
    inst_sram_req = 1'b0;
    tick();
  endtask

  task automatic test_rid_filter();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h2000_0000;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rid_addr_ok: got %b want 1", inst_sram_addr_ok);
    end
    exp_q.push_back(32'h0000_0000);
    tick();
    inst_sram_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'h3; rlast = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rready !== 1'b1 || inst_sram_data_ok !== 1'b0 || inst_sram_rdata !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL rid_drop: rready=%b data_ok=%b rdata=%h want 1/0/a5a50f0f",
               rready, inst_sram_data_ok, inst_sram_rdata);
    end
    tick();
    rid = 4'h0; rdata = 32'h0000_0000;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b1) begin
      errors++; $display("FAIL rid_match: data_ok=%b want 1", inst_sram_data_ok);
    end else begin
      exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      if (inst_sram_rdata !== exp_word) begin
        errors++; $display("FAIL rid_rdata: got %h want %h", inst_sram_rdata, exp_word);
      end
    end
    tick();
    rvalid = 1'b0;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b0 || inst_sram_rdata !== 32'h0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL rid_after: data_ok=%b rdata=%h rready=%b want 0/0/0",
               inst_sram_data_ok, inst_sram_rdata, rready);
    end
  endtask

  task automatic test_back_to_back();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL b2b_first_addr_ok: got %b want 1", inst_sram_addr_ok);
    end
    exp_q.push_back(32'h1111_1111);
    tick();
    inst_sram_addr = 32'hBFC0_0004; arready = 1'b1;
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || inst_sram_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_ar: arvalid=%b araddr=%h addr_ok=%b want 1/bfc00000/0",
               arvalid, araddr, inst_sram_addr_ok);
    end
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'h0; rlast = 1'b1; rdata = 32'h1111_1111;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_data: data_ok=%b addr_ok=%b arvalid=%b want 1/0/0",
               inst_sram_data_ok, inst_sram_addr_ok, arvalid);
    end
    if (inst_sram_data_ok === 1'b1) begin
      checks++;
      exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      if (inst_sram_rdata !== exp_word) begin
        errors++; $display("FAIL b2b_first_rdata: got %h want %h", inst_sram_rdata, exp_word);
      end
    end
    tick();
    rvalid = 1'b0;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL b2b_second_addr_ok: got %b want 1", inst_sram_addr_ok);
    end
    exp_q.push_back(32'h2222_2222);
    tick();
    inst_sram_req = 1'b0; arready = 1'b1;
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0004 || rready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_ar: arvalid=%b araddr=%h rready=%b want 1/bfc00004/0",
               arvalid, araddr, rready);
    end
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h2222_2222;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b1 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_data: data_ok=%b arvalid=%b want 1/0", inst_sram_data_ok, arvalid);
    end else begin
      exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      if (inst_sram_rdata !== exp_word) begin
        errors++; $display("FAIL b2b_second_rdata: got %h want %h", inst_sram_rdata, exp_word);
      end
    end
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h3000_0000;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rmid_addr_ok: got %b want 1", inst_sram_addr_ok);
    end
    exp_q.push_back(32'h5555_5555);
    tick();
    inst_sram_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    checks++;
    if (rready !== 1'b1) begin
      errors++; $display("FAIL rmid_in_r: rready=%b want 1", rready);
    end
    resetn = 1'b0;
    rvalid = 1'b1; rid = 4'h0; rlast = 1'b1; rdata = 32'h5555_5555;
    #1;
    checks++;
    if (inst_sram_data_ok !== 1'b0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_during: data_ok=%b rready=%b want 0/0", inst_sram_data_ok, rready);
    end
    exp_q.delete();
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if ({inst_sram_data_ok, rready, arvalid} !== 3'b000 || inst_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rmid_after: dok/rready/arvalid=%b rdata=%h want 000/0",
               {inst_sram_data_ok, rready, arvalid}, inst_sram_rdata);
    end
    inst_sram_req = 1'b1;
    #1;
    checks++;
    if (inst_sram_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rmid_idle: addr_ok=%b want 1", inst_sram_addr_ok);
    end
    inst_sram_req = 1'b0;
    tick();
    #1;
    checks++;
    if ({inst_sram_data_ok, rready, arvalid} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_late_beat: dok/rready/arvalid=%b want 000", {inst_sram_data_ok, rready, arvalid});
    end
    rvalid = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 1'b0; inst_sram_wen = 4'h0;
    inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    test_reset();
    test_basic_fetch();
    test_ar_stall();
    test_rid_filter();
    test_back_to_back();
    test_reset_mid_transfer();

    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_axi_rbridge.md
INST_AXI_RBRIDGE -- requirements
Module: inst_axi_rbridge

Interface
REQ-001 Parameter: ARID, default 4'h0, AXI read ID driven on arid for every fetch.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 inst_sram_req  in  1  fetch request from IF stage.
REQ-005 inst_sram_wen  in  4  write enables; ignored, instruction side is read-only.
REQ-006 inst_sram_addr  in  32  physical fetch address (word aligned).
REQ-007 inst_sram_wdata  in  32  ignored.
REQ-008 inst_sram_addr_ok  out  1  request accepted this cycle.
REQ-009 inst_sram_data_ok  out  1  one-cycle pulse; rdata valid.
REQ-010 inst_sram_rdata  out  32  fetched instruction word.
REQ-011 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  4/32/8/3/2/2/4/3  AXI AR payload.
REQ-012 arvalid  out  1; arready  in  1  AR handshake.
REQ-013 rid/rdata/rresp/rlast  in  4/32/2/1  AXI R payload.
REQ-014 rvalid  in  1; rready  out  1  R handshake.

Function
REQ-015 FSM states SHALL be IDLE, AR, R; at most one request is outstanding at any time.
REQ-016 inst_sram_addr_ok SHALL equal inst_sram_req && (state==IDLE), combinationally.
REQ-017 On addr_ok, araddr SHALL be registered from inst_sram_addr and state SHALL go IDLE->AR.
REQ-018 In AR, arvalid SHALL be 1 and araddr stable until arready; on arvalid&&arready, state SHALL go AR->R.
REQ-019 arvalid SHALL be 0 in IDLE and R; arvalid SHALL NOT be withdrawn before arready.
REQ-020 Constant payload: arid=ARID, arlen=0, arsize=3'b010, arburst=2'b01, arlock=0, arcache=0, arprot=0.
REQ-021 rready SHALL be 1 only in state R.
REQ-022 In R, a beat with rvalid && rid==ARID && rlast SHALL assert inst_sram_data_ok that cycle, drive inst_sram_rdata=rdata, and go R->IDLE.
REQ-023 In R, beats with rid!=ARID SHALL be consumed (rready=1) and dropped: no data_ok, state unchanged.
REQ-024 rresp SHALL NOT affect behaviour; data is returned for every accepted request.
REQ-025 inst_sram_rdata SHALL hold the last returned word outside data_ok cycles (registered copy).
REQ-026 Minimum latency: req accepted cycle T, arvalid T+1; with arready at T+1 and rvalid at T+2, data_ok at T+2.
REQ-027 A new request SHALL NOT be accepted in the data_ok cycle; earliest next addr_ok is the following cycle.
REQ-028 Every accepted request SHALL produce exactly one data_ok; IF-side flush does not cancel an in-flight transfer (IF discards the response itself).
REQ-029 inst_sram_wen and inst_sram_wdata SHALL have no effect on any output.

Reset
REQ-030 While resetn==0 at a rising edge: state<=IDLE, araddr<=0, held rdata<=0.
REQ-031 During and directly after reset: arvalid=0, rready=0, inst_sram_data_ok=0, inst_sram_addr_ok=0.
REQ-032 Reset mid-transfer (AR or R) SHALL abandon the transfer; no data_ok is issued for it afterward.

Verification
REQ-033 Req addr=0xBFC00000, arready=1 immediately, rvalid+rlast next cycle rdata=0x3C1D0001 -> addr_ok T, arvalid T+1 araddr=0xBFC00000 arlen=0 arsize=2, data_ok T+2 rdata=0x3C1D0001.
REQ-034 arready held 0 for 5 cycles, req kept high -> arvalid/araddr stable all 5 cycles, addr_ok stays 0 until back in IDLE after data_ok.
REQ-035 In R, beat rid=4'h3 (ARID=0) then rid=0 rdata=0x00000000 -> first beat dropped with no data_ok, data_ok only on second.
REQ-036 Back-to-back reqs 0xBFC00000/0xBFC00004 -> two AR transactions, never overlapping; second addr_ok the cycle after first data_ok.
REQ-037 resetn=0 while in R, rvalid arriving after release -> no data_ok, rready=0, state IDLE, arvalid=0.
